branch_pht: RTL and testbench

BRANCH_PHT -- requirements
Module: branch_pht

---
 rtl/branch_pht_pkg.sv | 18 +
 rtl/branch_pht_if.sv | 24 ++
 rtl/saturated_adder.sv | 17 +
 rtl/branch_pht.sv | 103 ++++++++++
 tb/tb_branch_pht.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/branch_pht_pkg.sv
// Shared predictor definitions: FSM states, default geometry and counter init value.
package branch_pht_pkg;

    typedef enum logic {
        PHT_INIT,
        PHT_READY
    } pht_state_e;

    localparam int DEF_CNT_WIDTH  = 2;
    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_GHR_BITS   = 6;

    // Weakly-not-taken: MSB clear, all lower bits set (2'b01 for 2-bit counters).
    function automatic logic [31:0] weak_not_taken(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_pht_if.sv
// Fetch-side prediction and resolve-side update signals of the pattern history table.
interface branch_pht_if
    import branch_pht_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
);
    logic [31:0]           fetch_pc_i;
    logic                  pred_taken_o;
    logic [INDEX_BITS-1:0] pred_idx_o;
    logic                  busy_o;
    logic                  update_valid_i;
    logic [INDEX_BITS-1:0] update_idx_i;
    logic                  update_taken_i;

    modport master (
        output fetch_pc_i, update_valid_i, update_idx_i, update_taken_i,
        input  pred_taken_o, pred_idx_o, busy_o
    );

    modport slave (
        input  fetch_pc_i, update_valid_i, update_idx_i, update_taken_i,
        output pred_taken_o, pred_idx_o, busy_o
    );
endinterface

// File: rtl/saturated_adder.sv
// Up/down step of an unsigned counter that clamps at zero and all-ones instead of wrapping.
module saturated_adder #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] value,
    input  logic             up,
    output logic [WIDTH-1:0] result
);
    always_comb begin
        result = value;
        if (up && (value != '1)) begin
            result = value + WIDTH'(1);
        end else if (!up && (value != '0)) begin
            result = value - WIDTH'(1);
        end
    end
endmodule

// File: rtl/branch_pht.sv
// Gshare-style pattern history table with non-speculative global history,
// a one-entry-per-cycle init sweep after reset, and same-cycle update bypass.
module branch_pht
    import branch_pht_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int GHR_BITS   = DEF_GHR_BITS
) (
    input  logic        clk_i,
    input  logic        rst_i,
    branch_pht_if.slave bus
);
    localparam int                    DEPTH    = 1 << INDEX_BITS;
    localparam logic [CNT_WIDTH-1:0]  CNT_INIT = CNT_WIDTH'(weak_not_taken(CNT_WIDTH));
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(DEPTH - 1);

    pht_state_e            state_q;
    pht_state_e            state_d;
    logic [INDEX_BITS-1:0] sweep_ptr_q;
    logic [GHR_BITS-1:0]   ghr_q;
    logic [CNT_WIDTH-1:0]  pht_q [DEPTH];

    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] pred_idx;
    logic [CNT_WIDTH-1:0]  cnt_cur;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic [CNT_WIDTH-1:0]  pred_cnt;
    logic                  sweep_en;
    logic                  upd_en;
    logic                  bypass;
    logic                  unused_pc;

    assign unused_pc = ^{bus.fetch_pc_i[31:INDEX_BITS+2], bus.fetch_pc_i[1:0]};

    // Index uses the history as it stands before any shift at this edge.
    assign ghr_ext        = INDEX_BITS'(ghr_q);
    assign pred_idx       = bus.fetch_pc_i[INDEX_BITS+1:2] ^ ghr_ext;
    assign bus.pred_idx_o = pred_idx;

    assign cnt_cur = pht_q[bus.update_idx_i];

    saturated_adder #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt_step (
        .value  (cnt_cur),
        .up     (bus.update_taken_i),
        .result (cnt_next)
    );

    assign bypass   = upd_en && (bus.update_idx_i == pred_idx);
    assign pred_cnt = bypass ? cnt_next : pht_q[pred_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PHT_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PHT_INIT:  if (sweep_ptr_q == LAST_IDX) state_d = PHT_READY;
            PHT_READY: state_d = PHT_READY;
            default:   state_d = PHT_INIT;
        endcase
    end

    always_comb begin
        sweep_en         = 1'b0;
        upd_en           = 1'b0;
        bus.busy_o       = 1'b1;
        bus.pred_taken_o = 1'b0;
        if (state_q == PHT_READY) begin
            upd_en           = bus.update_valid_i;
            bus.busy_o       = 1'b0;
            bus.pred_taken_o = pred_cnt[CNT_WIDTH-1];
        end else begin
            sweep_en         = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sweep_ptr_q <= '0;
            ghr_q       <= '0;
        end else begin
            if (sweep_en) sweep_ptr_q <= sweep_ptr_q + INDEX_BITS'(1);
            if (upd_en)   ghr_q       <= GHR_BITS'({ghr_q, bus.update_taken_i});
        end
    end

    // Counter storage is never reset; the sweep defines every entry before use.
    always_ff @(posedge clk_i) begin
        if (sweep_en) begin
            pht_q[sweep_ptr_q] <= CNT_INIT;
        end else if (upd_en) begin
            pht_q[bus.update_idx_i] <= cnt_next;
        end
    end
endmodule

// File: tb/tb_branch_pht.sv
// Self-checking bench for branch_pht: directed vector table, hand sequences and
// randomized traffic compared against an arithmetic predictor model.
module tb_branch_pht;
    localparam int IB    = 6;
    localparam int CW    = 2;
    localparam int GB    = 6;
    localparam int DEPTH = 1 << IB;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct {
        logic        uv;
        int          uidx;
        logic        ut;
        logic [31:0] pc;
        int          exp_idx;
        logic        exp_taken;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_pht_if #(.INDEX_BITS(IB)) pht_bus ();

    branch_pht #(
        .CNT_WIDTH  (CW),
        .INDEX_BITS (IB),
        .GHR_BITS   (GB)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (pht_bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: counters as integers, history as an integer, init as a countdown.
    int m_cnt [DEPTH];
    int m_ghr       = 0;
    int m_init_left = 0;
    bit m_known     = 1'b0;

    logic          last_busy;
    logic          last_taken;
    logic [IB-1:0] last_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic [31:0] pc, input logic uv,
                         input int uidx, input logic ut);
        int   eidx;
        int   newc;
        int   ui;
        logic ebusy;
        logic etaken;
        ui = uidx & (DEPTH - 1);
        rst                    = r;
        pht_bus.fetch_pc_i     = pc;
        pht_bus.update_valid_i = uv;
        pht_bus.update_idx_i   = IB'(ui);
        pht_bus.update_taken_i = ut;
        @(negedge clk);
        last_busy  = pht_bus.busy_o;
        last_taken = pht_bus.pred_taken_o;
        last_idx   = pht_bus.pred_idx_o;
        eidx  = ((pc >> 2) & (DEPTH - 1)) ^ m_ghr;
        ebusy = (m_init_left > 0);
        newc  = ut ? ((m_cnt[ui] < CMAX) ? m_cnt[ui] + 1 : CMAX)
                   : ((m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0);
        if (m_known) begin
            if (ebusy)                  etaken = 1'b0;
            else if (uv && ui == eidx)  etaken = (newc >= (1 << (CW - 1)));
            else                        etaken = (m_cnt[eidx] >= (1 << (CW - 1)));
            check("model_busy", 32'(last_busy), 32'(ebusy));
            check("model_idx", 32'(last_idx), 32'(eidx));
            check("model_taken", 32'(last_taken), 32'(etaken));
        end
        if (r) begin
            m_known     = 1'b1;
            m_init_left = DEPTH;
            m_ghr       = 0;
        end else if (m_init_left > 0) begin
            m_init_left--;
            if (m_init_left == 0) begin
                for (int k = 0; k < DEPTH; k++) m_cnt[k] = (1 << (CW - 1)) - 1;
            end
        end else if (uv) begin
            m_cnt[ui] = newc;
            m_ghr     = ((m_ghr << 1) | int'(ut)) & ((1 << GB) - 1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [13];
        int   busy_cnt;
        logic [31:0] rpc;
        int   ruidx;

        vecs[0]  = '{1'b1,  5, 1'b1, 32'h0000_0014,  5, 1'b1};
        vecs[1]  = '{1'b1,  5, 1'b1, 32'h0000_0014,  4, 1'b0};
        vecs[2]  = '{1'b1,  5, 1'b1, 32'h0000_0018,  5, 1'b1};
        vecs[3]  = '{1'b0,  0, 1'b0, 32'h0000_0008,  5, 1'b1};
        vecs[4]  = '{1'b1, 20, 1'b0, 32'h0000_0008,  5, 1'b1};
        vecs[5]  = '{1'b1, 20, 1'b0, 32'h0000_0068, 20, 1'b0};
        vecs[6]  = '{1'b1, 20, 1'b0, 32'h0000_0068,  6, 1'b0};
        vecs[7]  = '{1'b0,  0, 1'b0, 32'h0000_00B0, 20, 1'b0};
        vecs[8]  = '{1'b1,  9, 1'b1, 32'h0000_00C4,  9, 1'b1};
        vecs[9]  = '{1'b0,  0, 1'b0, 32'h0000_00E0,  9, 1'b1};
        vecs[10] = '{1'b1,  9, 1'b0, 32'h0000_00E0,  9, 1'b0};
        vecs[11] = '{1'b0,  0, 1'b0, 32'h0000_0000, 34, 1'b0};
        vecs[12] = '{1'b0,  0, 1'b0, 32'hFFFF_FF03, 34, 1'b0};

        rst = 1'b1;
        pht_bus.fetch_pc_i     = '0;
        pht_bus.update_valid_i = 1'b0;
        pht_bus.update_idx_i   = '0;
        pht_bus.update_taken_i = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 32'h0, 1'b0, 0, 1'b0);

        // Init sweep: busy for exactly DEPTH cycles, updates ignored meanwhile.
        busy_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                  1'($urandom_range(0, 1)));
            if (last_busy === 1'b1) busy_cnt++;
        end
        check("init_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
        cycle(1'b0, 32'h0, 1'b0, 0, 1'b0);
        check("ready_after_init", 32'(last_busy), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 32'(i << 2), 1'b0, 0, 1'b0);
            check("init_entry_idx", 32'(last_idx), 32'(i));
            check("init_entry_taken", 32'(last_taken), 32'd0);
        end

        foreach (vecs[i]) begin
            cycle(1'b0, vecs[i].pc, vecs[i].uv, vecs[i].uidx, vecs[i].ut);
            check($sformatf("vec%0d_idx", i), 32'(last_idx), 32'(vecs[i].exp_idx));
            check($sformatf("vec%0d_taken", i), 32'(last_taken), 32'(vecs[i].exp_taken));
        end

        // History shift: taken, taken, not-taken from zero gives 6'b000110.
        cycle(1'b1, 32'h0, 1'b0, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b0, 0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 0, 1'b0);
        cycle(1'b0, 32'h0000_0010, 1'b0, 0, 1'b0);
        check("ghr_idx", 32'(last_idx), 32'b000010);

        // Reset mid-sweep with an update pending: sweep restarts, history cleared.
        cycle(1'b1, 32'h0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 32'h0, 1'b1, i, 1'b1);
        cycle(1'b1, 32'h0, 1'b1, 7, 1'b1);
        check("rst_mid_sweep_busy", 32'(last_busy), 32'd1);
        busy_cnt = 0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            cycle(1'b0, 32'h0000_0010, 1'b0, 0, 1'b0);
            if (last_busy !== 1'b1) break;
            busy_cnt++;
        end
        check("restart_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
        check("restart_ghr_idx", 32'(last_idx), 32'd4);

        for (int i = 0; i < 600; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 2) == 0) ruidx = ((rpc >> 2) & (DEPTH - 1)) ^ m_ghr;
            else                           ruidx = $urandom_range(0, DEPTH - 1);
            cycle(1'($urandom_range(0, 199) == 0), rpc, 1'($urandom_range(0, 3) != 0), ruidx,
                  1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
